// File: rtl/fifo_wr_arbiter_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fifo_wr_arbiter_if : producer request/grant bus plus FIFO write-port signals
// Rev 1.0
// ---------------------------------------------------------------------------
interface fifo_wr_arbiter_if #(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 4
);
   localparam int ID_W = $clog2(NUM_REQ);

   logic [NUM_REQ-1:0]            req;
   logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
   logic [NUM_REQ-1:0]            gnt;
   logic [NUM_REQ-1:0]            ack;
   logic [ID_W-1:0]               gnt_id;
   logic                          busy;
   logic                          fifo_wr_en;
   logic [DATA_WIDTH-1:0]         fifo_wr_data;
   logic                          fifo_full;
   logic                          fifo_afull;

   // Producers and FIFO flags side
   modport master (
      output req, req_data, fifo_full, fifo_afull,
      input  gnt, ack, gnt_id, busy, fifo_wr_en, fifo_wr_data
   );

   // Arbiter side
   modport slave (
      input  req, req_data, fifo_full, fifo_afull,
      output gnt, ack, gnt_id, busy, fifo_wr_en, fifo_wr_data
   );
endinterface
`default_nettype wire

// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fifo_wr_arbiter : round-robin burst arbiter in front of one FIFO write port.
// Optional macro FIFO_WR_ARB_AFULL_EN blocks new grants while fifo_afull = 1.
// Rev 1.0
// ---------------------------------------------------------------------------
module fifo_wr_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 4,
   parameter int MAX_BURST  = 4
) (
   input  wire             clk,
   input  wire             rst,
   fifo_wr_arbiter_if.slave bus
);
   localparam int ID_W  = $clog2(NUM_REQ);
   localparam int CNT_W = $clog2(MAX_BURST + 1);

   localparam logic [0:0] IDLE  = 1'b0;
   localparam logic [0:0] BURST = 1'b1;

   logic [0:0]         state_q,     state_d;
   logic [NUM_REQ-1:0] gnt_q,       gnt_d;
   logic [ID_W-1:0]    gnt_id_q,    gnt_id_d;
   logic [CNT_W-1:0]   burst_cnt_q, burst_cnt_d;
   logic               busy_q,      busy_d;

   logic               sel_found;
   logic [ID_W-1:0]    sel_idx;
   logic [ID_W-1:0]    cand;
   logic               grant_ok;
   logic               req_g;
   logic               xfer;
   logic               last_word;

`ifdef FIFO_WR_ARB_AFULL_EN
   assign grant_ok = ~bus.fifo_afull;
`else
   logic unused_afull;
   assign unused_afull = bus.fifo_afull;
   assign grant_ok     = 1'b1;
`endif

   // First set request searching upward from last+1, wrapping modulo NUM_REQ
   always_comb begin
      sel_found = 1'b0;
      sel_idx   = '0;
      cand      = '0;
      for (int i = 1; i <= NUM_REQ; i++) begin
         cand = ID_W'((int'(gnt_id_q) + i) % NUM_REQ);
         if (!sel_found && bus.req[cand]) begin
            sel_found = 1'b1;
            sel_idx   = cand;
         end
      end
   end

   assign req_g     = bus.req[gnt_id_q];
   assign xfer      = req_g & ~bus.fifo_full;
   assign last_word = (burst_cnt_q == CNT_W'(MAX_BURST - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         gnt_q       <= '0;
         gnt_id_q    <= ID_W'(NUM_REQ - 1);
         burst_cnt_q <= '0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         gnt_q       <= gnt_d;
         gnt_id_q    <= gnt_id_d;
         burst_cnt_q <= burst_cnt_d;
         busy_q      <= busy_d;
      end
   end

   // gnt_id doubles as the round-robin "last" pointer once a burst ends
   always_comb begin
      state_d     = state_q;
      gnt_d       = gnt_q;
      gnt_id_d    = gnt_id_q;
      burst_cnt_d = burst_cnt_q;
      busy_d      = busy_q;
      case (state_q)
         IDLE: begin
            if (sel_found && grant_ok) begin
               state_d     = BURST;
               gnt_d       = NUM_REQ'(1) << sel_idx;
               gnt_id_d    = sel_idx;
               burst_cnt_d = '0;
               busy_d      = 1'b1;
            end
         end
         BURST: begin
            if (!req_g || (xfer && last_word)) begin
               state_d = IDLE;
               gnt_d   = '0;
               busy_d  = 1'b0;
            end else if (xfer) begin
               burst_cnt_d = burst_cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = IDLE;
            gnt_d   = '0;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_comb begin
      bus.fifo_wr_en   = (state_q == BURST) && xfer;
      bus.ack          = bus.fifo_wr_en ? gnt_q : '0;
      bus.fifo_wr_data = bus.req_data[gnt_id_q*DATA_WIDTH +: DATA_WIDTH];
      bus.gnt          = gnt_q;
      bus.gnt_id       = gnt_id_q;
      bus.busy         = busy_q;
   end
endmodule
`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_fifo_wr_arbiter : directed checks of grant order, bursts, stall, abandon,
// almost-full throttle and mid-burst reset.  Rev 1.0
// ---------------------------------------------------------------------------
module tb_fifo_wr_arbiter;
   localparam int NUM_REQ    = 4;
   localparam int DATA_WIDTH = 4;
   localparam int MAX_BURST  = 4;

   logic clk = 1'b0;
   logic rst;
   int   total = 0;
   int   bad   = 0;
   int   words;

   always #5 clk = ~clk;

   fifo_wr_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_WIDTH(DATA_WIDTH)) bus ();

   fifo_wr_arbiter #(
      .NUM_REQ   (NUM_REQ),
      .DATA_WIDTH(DATA_WIDTH),
      .MAX_BURST (MAX_BURST)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst            = 1'b1;
      bus.req        = 4'b1111;
      bus.req_data   = {4'h8, 4'h7, 4'h6, 4'h5};
      bus.fifo_full  = 1'b0;
      bus.fifo_afull = 1'b0;

      // Reset held two cycles with all requesting
      step();
      check_eq("rst_gnt0", 32'(bus.gnt), 32'h0);
      check_eq("rst_gnt_id", 32'(bus.gnt_id), 32'd3);
      step();
      check_eq("rst_gnt1", 32'(bus.gnt), 32'h0);
      check_eq("rst_busy", 32'(bus.busy), 32'h0);
      check_eq("rst_wr_en", 32'(bus.fifo_wr_en), 32'h0);
      rst = 1'b0;
      step();

      // Round robin: four full bursts 0,1,2,3 over 20 cycles
      words = 0;
      for (int b = 0; b < 4; b++) begin
         for (int w = 0; w < 4; w++) begin
            check_eq("rr_gnt", 32'(bus.gnt), 32'(1) << b);
            check_eq("rr_ack", 32'(bus.ack), 32'(1) << b);
            check_eq("rr_data", 32'(bus.fifo_wr_data), 32'(5 + b));
            if (bus.fifo_wr_en) words++;
            step();
         end
         check_eq("rr_idle_gnt", 32'(bus.gnt), 32'h0);
         check_eq("rr_idle_wr", 32'(bus.fifo_wr_en), 32'h0);
         step();
      end
      check_eq("rr_words", 32'(words), 32'd16);
      check_eq("rr_wrap_gnt", 32'(bus.gnt), 32'h1);
      check_eq("rr_wrap_id", 32'(bus.gnt_id), 32'h0);

      // Mid-burst reset during the 3rd word
      step();
      step();
      rst = 1'b1;
      #1;
      check_eq("mrst_ack", 32'(bus.ack), 32'h1);
      step();
      check_eq("mrst_gnt", 32'(bus.gnt), 32'h0);
      check_eq("mrst_id", 32'(bus.gnt_id), 32'd3);
      check_eq("mrst_busy", 32'(bus.busy), 32'h0);
      rst = 1'b0;
      step();
      check_eq("mrst_next_gnt", 32'(bus.gnt), 32'h1);

      // Full stall at the 2nd word
      check_eq("full_w1_ack", 32'(bus.ack), 32'h1);
      for (int k = 0; k < 3; k++) begin
         step();
         bus.fifo_full = 1'b1;
         #1;
         check_eq("full_wr_en", 32'(bus.fifo_wr_en), 32'h0);
         check_eq("full_ack", 32'(bus.ack), 32'h0);
         check_eq("full_gnt", 32'(bus.gnt), 32'h1);
      end
      step();
      bus.fifo_full = 1'b0;
      #1;
      for (int w = 0; w < 3; w++) begin
         check_eq("full_resume_ack", 32'(bus.ack), 32'h1);
         check_eq("full_resume_data", 32'(bus.fifo_wr_data), 32'h5);
         step();
      end
      check_eq("full_end_gnt", 32'(bus.gnt), 32'h0);
      step();
      check_eq("full_next_gnt", 32'(bus.gnt), 32'h2);

      // Abandon: requester 1 drops immediately, then requester 2 after one word
      bus.req = 4'b0000;
      #1;
      check_eq("ab1_ack", 32'(bus.ack), 32'h0);
      step();
      check_eq("ab1_busy", 32'(bus.busy), 32'h0);
      bus.req = 4'b0100;
      step();
      check_eq("ab2_gnt", 32'(bus.gnt), 32'h4);
      check_eq("ab2_ack", 32'(bus.ack), 32'h4);
      check_eq("ab2_data", 32'(bus.fifo_wr_data), 32'h7);
      step();
      bus.req = 4'b1001;
      #1;
      check_eq("ab2_drop_wr", 32'(bus.fifo_wr_en), 32'h0);
      step();
      check_eq("ab2_idle_busy", 32'(bus.busy), 32'h0);
      check_eq("ab2_idle_gnt", 32'(bus.gnt), 32'h0);
      step();
      check_eq("ab2_next_gnt", 32'(bus.gnt), 32'h8);
      check_eq("ab2_next_id", 32'(bus.gnt_id), 32'd3);

      // Almost-full throttle with a request from requester 2
      bus.req = 4'b0000;
      step();
      check_eq("af_idle", 32'(bus.busy), 32'h0);
      bus.req        = 4'b0100;
      bus.fifo_afull = 1'b1;
      step();
`ifdef FIFO_WR_ARB_AFULL_EN
      check_eq("af_hold0", 32'(bus.gnt), 32'h0);
      step();
      check_eq("af_hold1", 32'(bus.gnt), 32'h0);
      bus.fifo_afull = 1'b0;
      step();
      check_eq("af_gnt", 32'(bus.gnt), 32'h4);
      bus.fifo_afull = 1'b1;
      #1;
      check_eq("af_burst_ack", 32'(bus.ack), 32'h4);
`else
      check_eq("af_gnt", 32'(bus.gnt), 32'h4);
      #1;
      check_eq("af_burst_ack", 32'(bus.ack), 32'h4);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
`default_nettype wire
